conv_load_ddr_controller: RTL and testbench
===========================================

// Module: conv_load_ddr_controller
// PURPOSE
// Loads one input-feature tile from DDR into the conv core's row input buffers; read-side counterpart of the conv output store path.
// Walks tile rows (iy) and channel chunks (if), issues one DDR read burst per chunk, accepts 512-bit read words
// and writes them into the row buffer selected by iy: two 256-bit channel writes per word in mode 0, one 512-bit write in mode 1.
// DDR layout is identical to the store path: one 512-bit word = 2 channels x 32 pixels.
// PARAMETERS
// pixels_in_row_in_2pow  5   log2 pixels per DDR word per channel
// ofs_in_row_2pow        1   log2 channels per DDR word
// buf_rows               3   number of row input buffers (max cur_piy)
// max_burst_words        16  max words per DDR read command
// PORTS
// clk                 in   1    clock
// reset               in   1    synchronous, active-high
// conv_load_start     in   1    pulse: begin tile load (ignored while busy)
// input_ddr_layer_base_adr in 32  layer base word address
// mode                in   4    0: 8b (256b/channel write), 1: 512b write; others: treated as 0
// if_in_2pow, ix_in_2pow in 4  log2 layer channels / layer width
// cur_ix_start, cur_iy_start, cur_if_start in 16  tile origin, 1-based
// cur_piy, cur_pif    in   16   tile rows (1..buf_rows), tile channels (1..)
// ddr_cmd_ready       in   1    DDR accepts a read command this cycle
// load_ddr_base_adr   out  32   read command word address (comb.)
// load_ddr_length     out  16   read command length in words (comb.)
// valid_ddr_cmd       out  1    command handshake, = ddr_cmd_ready && state==CMD
// ddr_rd_data         in   512  read data word
// valid_ddr_rd_data   in   1    read data valid
// ddr_rd_data_ready   out  1    word accepted when valid && ready
// buf_we              out  buf_rows  one-hot row buffer write enable (registered)
// buf_wr_adr          out  16   channel slot in buffer (mode 0: channel idx; mode 1: channel-pair idx)
// buf_wr_data         out  512  write data; mode 0 uses [255:0], [511:256]=0
// busy                out  1    high from accepted start until done
// conv_load_done      out  1    1-cycle pulse after last buffer write
// BEHAVIOUR
// Reset: state IDLE, iy_counter=1, if_counter=1, word_cnt=0, half=0; all outputs 0 (incl. ddr_rd_data_ready).
// FSM: IDLE -start-> CMD -valid_ddr_cmd-> DATA -last word consumed-> CMD (more chunks) | DONE; DONE -> IDLE after 1 cycle.
// Chunk: rem = cur_pif - if_counter + 1; load_ddr_length = min(max_burst_words, (rem+1)>>1) (odd pif rounds up).
// load_ddr_base_adr = base + ((cur_iy_start+iy_counter-2) << (if_in_2pow-1+ix_in_2pow-5))
//   + (((cur_ix_start-1) << (if_in_2pow-1)) >> 5) + ((cur_if_start+if_counter-2) >> 1); shifts 32-bit, unsigned.
// DATA, mode 1: ready=1; each accepted word -> next cycle buf_we[iy-1]=1, adr=(if_counter-1)/2+word_cnt, data=word.
// DATA, mode 0: word latched into hold reg; cycle A writes low half (channel c), cycle B writes high half (c+1);
//   ready=0 while hold full, so max 1 word per 2 cycles; high half write suppressed if c+1 > cur_pif.
// Chunk end: word_cnt==load_ddr_length-1 consumed -> if_counter += length<<1; if past cur_pif -> if_counter=1, iy_counter+=1;
//   iy_counter==cur_piy at chunk end -> DONE. conv_load_done asserted in DONE, after final buf_we cycle.
// Write latency: 1 cycle from accept (mode 1) / from hold load (mode 0). ready held 0 outside DATA; valid outside DATA dropped.
// conv_load_start while busy: ignored. start and DONE same cycle: start ignored.
// Reset mid-operation: abort, return to IDLE, no done pulse; outstanding DDR words are the DDR side's concern.
// STRUCTURE
// Shared package: mode encodings (MODE_8B=0, MODE_4B=1), DDR word width 512, state enum IDLE/CMD/DATA/DONE.
// Address formula is shared with the store controller: one function conv_ddr_word_adr(base,y,x,f,shifts) in package.
// Sub-module: conv_load_word_splitter (hold reg + half select + ready) for the mode 0 512->256 split.
// TESTING
// mode1, piy=1, pif=32, starts=1, base=0x1000, if2pow=5, ix2pow=5 -> 1 cmd adr 0x1000 len 16; 16 writes adr 0..15, buf_we=001.
// mode0, same tile -> 16 words, 32 writes adr 0..31 alternating low/high halves, ready toggles 1/0; done 1 cycle after last.
// mode1, pif=40 -> cmds len 16 then len 4 (adr +16); writes adr 0..19; piy=3 -> rows 1,2,3 via buf_we 001,010,100.
// mode0, pif=5 -> len 3; 5 writes; 6th (high half of word 2) suppressed.
// ddr_cmd_ready held low 10 cycles -> no valid_ddr_cmd, state stays CMD; start re-pulsed while busy -> no effect.
// reset asserted in mid-DATA -> next cycle all outputs 0, IDLE; subsequent start performs full load correctly.

Source files
------------

// File: rtl/conv_load_ddr_controller_pkg.sv
// Shared definitions for the conv DDR load/store paths.
// Contents:
//   - DDR word geometry (512-bit word = 2 channels x 32 pixels x 8 bit)
//   - mode encodings (MODE_8B, MODE_4B)
//   - controller state enum (IDLE/CMD/DATA/DONE)
//   - conv_ddr_word_adr(): tile-origin to DDR word address, shared with the store path
package conv_load_ddr_controller_pkg;

   localparam int DDR_WORD_W = 512;
   localparam int HALF_W     = 256;

   localparam logic [3:0] MODE_8B = 4'd0;
   localparam logic [3:0] MODE_4B = 4'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   // Word address of pixel row y, column x, channel f (all 0-based).
   // One DDR word holds 2^ofs_2pow channels x 2^pix_2pow pixels, so a row of
   // the layer spans 2^(if_2pow-ofs_2pow+ix_2pow-pix_2pow) words. Negative
   // shift amounts (layers smaller than one word) clamp to zero.
   function automatic logic [31:0] conv_ddr_word_adr(
      input logic [31:0] base,
      input logic [31:0] y,
      input logic [31:0] x,
      input logic [31:0] f,
      input logic [3:0]  if_2pow,
      input logic [3:0]  ix_2pow,
      input int          pix_2pow,
      input int          ofs_2pow
   );
      int rs;
      int cs;
      logic [5:0] row_sh;
      logic [5:0] ch_sh;
      rs = int'(if_2pow) - ofs_2pow + int'(ix_2pow) - pix_2pow;
      cs = int'(if_2pow) - ofs_2pow;
      row_sh = (rs < 0) ? 6'd0 : 6'(rs);
      ch_sh  = (cs < 0) ? 6'd0 : 6'(cs);
      return base + (y << row_sh) + ((x << ch_sh) >> pix_2pow) + (f >> ofs_2pow);
   endfunction

endpackage

// File: rtl/conv_load_word_splitter.sv
// Splits a 512-bit DDR word into two 256-bit channel writes (8-bit mode).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   en           splitter may accept a word this cycle
//   word         incoming DDR word
//   word_valid   incoming word valid
//   ready        word accepted when word_valid && ready (low while hold is full)
//   wr_lo        low-half write this cycle (the word being accepted)
//   wr_hi        high-half write this cycle (taken from the hold register)
//   wr_data      256-bit data for whichever half is being written
module conv_load_word_splitter
   import conv_load_ddr_controller_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [DDR_WORD_W-1:0] word,
   input  logic                  word_valid,
   output logic                  ready,
   output logic                  wr_lo,
   output logic                  wr_hi,
   output logic [HALF_W-1:0]     wr_data
);

   logic              full;
   logic [HALF_W-1:0] hold;

   // The low half goes straight through on accept; only the high half is
   // parked, which is what limits throughput to one word every two cycles.
   assign ready   = en && !full;
   assign wr_lo   = ready && word_valid;
   assign wr_hi   = full;
   assign wr_data = full ? hold : word[HALF_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         full <= 1'b0;
         hold <= '0;
      end else if (wr_lo) begin
         full <= 1'b1;
         hold <= word[DDR_WORD_W-1:HALF_W];
      end else if (full) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/conv_load_ddr_controller.sv
// Loads one input-feature tile from DDR into the conv core's row buffers.
// Walks tile rows (iy) and channel chunks (if), issues one DDR read burst per
// chunk and writes the returned words into the row buffer selected by iy.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   conv_load_start              start pulse (ignored while busy)
//   input_ddr_layer_base_adr     layer base word address
//   mode                         0: 8b (two 256b channel writes/word), 1: one 512b write; others as 0
//   if_in_2pow, ix_in_2pow       log2 layer channels / width
//   cur_ix/iy/if_start           tile origin, 1-based
//   cur_piy, cur_pif             tile rows, tile channels
//   ddr_cmd_ready                DDR read-command side ready
//   load_ddr_base_adr/length     read command (valid only in CMD, else 0)
//   valid_ddr_cmd                command handshake
//   ddr_rd_data, valid_ddr_rd_data, ddr_rd_data_ready   read data stream
//   buf_we, buf_wr_adr, buf_wr_data  registered row-buffer write port
//   busy, conv_load_done         status
module conv_load_ddr_controller
   import conv_load_ddr_controller_pkg::*;
#(
   parameter int pixels_in_row_in_2pow = 5,
   parameter int ofs_in_row_2pow       = 1,
   parameter int buf_rows              = 3,
   parameter int max_burst_words       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  conv_load_start,
   input  logic [31:0]           input_ddr_layer_base_adr,
   input  logic [3:0]            mode,
   input  logic [3:0]            if_in_2pow,
   input  logic [3:0]            ix_in_2pow,
   input  logic [15:0]           cur_ix_start,
   input  logic [15:0]           cur_iy_start,
   input  logic [15:0]           cur_if_start,
   input  logic [15:0]           cur_piy,
   input  logic [15:0]           cur_pif,
   input  logic                  ddr_cmd_ready,
   output logic [31:0]           load_ddr_base_adr,
   output logic [15:0]           load_ddr_length,
   output logic                  valid_ddr_cmd,
   input  logic [DDR_WORD_W-1:0] ddr_rd_data,
   input  logic                  valid_ddr_rd_data,
   output logic                  ddr_rd_data_ready,
   output logic [buf_rows-1:0]   buf_we,
   output logic [15:0]           buf_wr_adr,
   output logic [DDR_WORD_W-1:0] buf_wr_data,
   output logic                  busy,
   output logic                  conv_load_done
);

   state_t state, state_next;

   logic [15:0] iy_counter;
   logic [15:0] if_counter;
   logic [15:0] word_cnt;

   logic [16:0] rem;
   logic [16:0] half_words;
   logic [16:0] if_next;
   logic [15:0] chunk_len;
   logic [31:0] cmd_adr;
   logic        mode_wide;
   logic        words_left;
   logic        last_in_row;
   logic        last_row;
   logic        chunk_end;
   logic        accept;
   logic [buf_rows-1:0] row_oh;
   logic [15:0] word_adr;
   logic [15:0] chan_adr;
   logic        hi_keep;

   logic              sp_en;
   logic              sp_ready;
   logic              sp_wr_lo;
   logic              sp_wr_hi;
   logic [HALF_W-1:0] sp_wr_data;

   assign mode_wide = (mode == MODE_4B);

   // Chunk sizing: remaining channels in this row, two channels per word,
   // odd counts round up to a full word.
   assign rem        = {1'b0, cur_pif} - {1'b0, if_counter} + 17'd1;
   assign half_words = (rem + 17'd1) >> 1;
   assign chunk_len  = (half_words > 17'(max_burst_words)) ? 16'(max_burst_words)
                                                           : half_words[15:0];
   assign if_next    = {1'b0, if_counter} + {chunk_len, 1'b0};
   assign last_in_row = (if_next > {1'b0, cur_pif});
   assign last_row    = (iy_counter >= cur_piy);

   assign cmd_adr = conv_ddr_word_adr(
      input_ddr_layer_base_adr,
      {16'd0, cur_iy_start} + {16'd0, iy_counter} - 32'd2,
      {16'd0, cur_ix_start} - 32'd1,
      {16'd0, cur_if_start} + {16'd0, if_counter} - 32'd2,
      if_in_2pow, ix_in_2pow, pixels_in_row_in_2pow, ofs_in_row_2pow);

   assign words_left = (word_cnt < chunk_len);
   // Counters advance only once every word of the chunk is in and the
   // splitter has drained, so address terms stay stable for pending writes.
   assign chunk_end  = (state == DATA) && !words_left && !sp_wr_hi;

   assign sp_en             = (state == DATA) && words_left && !mode_wide;
   assign ddr_rd_data_ready = mode_wide ? ((state == DATA) && words_left) : sp_ready;
   assign accept            = valid_ddr_rd_data && ddr_rd_data_ready;

   assign valid_ddr_cmd     = ddr_cmd_ready && (state == CMD);
   assign load_ddr_length   = (state == CMD) ? chunk_len : 16'd0;
   assign load_ddr_base_adr = (state == CMD) ? cmd_adr : 32'd0;
   assign busy              = (state != IDLE);
   assign conv_load_done    = (state == DONE);

   for (genvar r = 0; r < buf_rows; r++) begin : g_row
      assign row_oh[r] = (iy_counter == 16'(r + 1));
   end

   assign word_adr = ((if_counter - 16'd1) >> 1) + word_cnt;
   assign chan_adr = (if_counter - 16'd1) + (word_cnt << 1);
   // High half carries channel buf_wr_adr+1 (0-based); drop it past the tile.
   assign hi_keep  = ({1'b0, buf_wr_adr} + 17'd2) <= {1'b0, cur_pif};

   conv_load_word_splitter u_splitter (
      .clk        (clk),
      .reset      (reset),
      .en         (sp_en),
      .word       (ddr_rd_data),
      .word_valid (valid_ddr_rd_data),
      .ready      (sp_ready),
      .wr_lo      (sp_wr_lo),
      .wr_hi      (sp_wr_hi),
      .wr_data    (sp_wr_data)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (conv_load_start) state_next = CMD;
         CMD:  if (valid_ddr_cmd)   state_next = DATA;
         DATA: if (chunk_end)       state_next = (last_in_row && last_row) ? DONE : CMD;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         iy_counter <= 16'd1;
         if_counter <= 16'd1;
         word_cnt   <= 16'd0;
      end else begin
         if (state == IDLE && conv_load_start) begin
            iy_counter <= 16'd1;
            if_counter <= 16'd1;
            word_cnt   <= 16'd0;
         end
         if (accept) word_cnt <= word_cnt + 16'd1;
         if (chunk_end) begin
            word_cnt <= 16'd0;
            if (last_in_row) begin
               if_counter <= 16'd1;
               iy_counter <= iy_counter + 16'd1;
            end else begin
               if_counter <= if_next[15:0];
            end
         end
      end
   end

   // Row-buffer write port. On the high-half cycle the row select is taken
   // from the low-half write still sitting in buf_we, one cycle earlier.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_we      <= '0;
         buf_wr_adr  <= 16'd0;
         buf_wr_data <= '0;
      end else if (accept && mode_wide) begin
         buf_we      <= row_oh;
         buf_wr_adr  <= word_adr;
         buf_wr_data <= ddr_rd_data;
      end else if (sp_wr_lo) begin
         buf_we      <= row_oh;
         buf_wr_adr  <= chan_adr;
         buf_wr_data <= {{HALF_W{1'b0}}, sp_wr_data};
      end else if (sp_wr_hi) begin
         buf_we      <= hi_keep ? buf_we : '0;
         buf_wr_adr  <= buf_wr_adr + 16'd1;
         buf_wr_data <= {{HALF_W{1'b0}}, sp_wr_data};
      end else begin
         buf_we      <= '0;
      end
   end

endmodule

// File: tb/tb_conv_load_ddr_controller.sv
module tb_conv_load_ddr_controller;

   logic         clk = 1'b0;
   logic         reset;
   logic         conv_load_start;
   logic [31:0]  input_ddr_layer_base_adr;
   logic [3:0]   mode, if_in_2pow, ix_in_2pow;
   logic [15:0]  cur_ix_start, cur_iy_start, cur_if_start, cur_piy, cur_pif;
   logic         ddr_cmd_ready;
   logic [31:0]  load_ddr_base_adr;
   logic [15:0]  load_ddr_length;
   logic         valid_ddr_cmd;
   logic [511:0] ddr_rd_data;
   logic         valid_ddr_rd_data;
   logic         ddr_rd_data_ready;
   logic [2:0]   buf_we;
   logic [15:0]  buf_wr_adr;
   logic [511:0] buf_wr_data;
   logic         busy, conv_load_done;

   always #5 clk = ~clk;

   conv_load_ddr_controller dut (
      .clk(clk), .reset(reset), .conv_load_start(conv_load_start),
      .input_ddr_layer_base_adr(input_ddr_layer_base_adr), .mode(mode),
      .if_in_2pow(if_in_2pow), .ix_in_2pow(ix_in_2pow),
      .cur_ix_start(cur_ix_start), .cur_iy_start(cur_iy_start), .cur_if_start(cur_if_start),
      .cur_piy(cur_piy), .cur_pif(cur_pif), .ddr_cmd_ready(ddr_cmd_ready),
      .load_ddr_base_adr(load_ddr_base_adr), .load_ddr_length(load_ddr_length),
      .valid_ddr_cmd(valid_ddr_cmd), .ddr_rd_data(ddr_rd_data),
      .valid_ddr_rd_data(valid_ddr_rd_data), .ddr_rd_data_ready(ddr_rd_data_ready),
      .buf_we(buf_we), .buf_wr_adr(buf_wr_adr), .buf_wr_data(buf_wr_data),
      .busy(busy), .conv_load_done(conv_load_done)
   );

   int n_chk = 0;
   int n_fail = 0;

   // observations from the last run_load
   int           ncmd, nwr, done_cnt, done_cyc, last_wr_cyc, nacc, adj_acc;
   int           cmd_in_hold, idle_in_hold;
   bit           timed_out, post_zero;
   logic [31:0]  cmd_adr [16];
   logic [15:0]  cmd_len [16];
   logic [2:0]   wr_we   [128];
   logic [15:0]  wr_adr  [128];
   logic [511:0] wr_data [128];

   function automatic logic [511:0] mk_word(input int k);
      logic [511:0] w;
      for (int l = 0; l < 16; l++) w[l*32 +: 32] = 32'hD000_0000 + 32'(k * 16 + l);
      return w;
   endfunction

   function automatic logic [511:0] half_of(input int k, input bit hi);
      logic [511:0] w;
      w = mk_word(k);
      return hi ? {256'd0, w[511:256]} : {256'd0, w[255:0]};
   endfunction

   // Drives one tile load with a simple DDR responder and records what the DUT does.
   task automatic run_load(input int md, input int piy, input int pif, input int if2, input int ix2,
                           input logic [31:0] base, input int iys, input int ixs, input int ifs,
                           input int hold, input bit restart, input int abort_at);
      int pend, widx, cyc;
      bit acc, prev_acc;
      ncmd = 0; nwr = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1; nacc = 0; adj_acc = 0;
      cmd_in_hold = 0; idle_in_hold = 0; timed_out = 1'b1; post_zero = 1'b0;
      pend = 0; widx = 0; prev_acc = 1'b0;
      @(negedge clk);
      mode = 4'(md); cur_piy = 16'(piy); cur_pif = 16'(pif);
      if_in_2pow = 4'(if2); ix_in_2pow = 4'(ix2); input_ddr_layer_base_adr = base;
      cur_iy_start = 16'(iys); cur_ix_start = 16'(ixs); cur_if_start = 16'(ifs);
      conv_load_start = 1'b1;
      @(negedge clk);
      for (cyc = 0; cyc < 600; cyc++) begin
         ddr_cmd_ready     = (cyc >= hold);
         conv_load_start   = restart && (cyc == 3);
         valid_ddr_rd_data = (pend > 0);
         ddr_rd_data       = mk_word(widx);
         reset             = (abort_at != 0) && (cyc == abort_at);
         #1;
         if (abort_at != 0 && cyc == abort_at + 1) begin
            post_zero = (buf_we == 0) && (buf_wr_adr == 0) && (buf_wr_data == 0) &&
                        !ddr_rd_data_ready && !valid_ddr_cmd && !busy && !conv_load_done &&
                        (load_ddr_length == 0) && (load_ddr_base_adr == 0);
            timed_out = 1'b0;
            break;
         end
         if (buf_we != 0 && nwr < 128) begin
            wr_we[nwr] = buf_we; wr_adr[nwr] = buf_wr_adr; wr_data[nwr] = buf_wr_data;
            nwr++; last_wr_cyc = cyc;
         end
         if (conv_load_done) begin done_cnt++; done_cyc = cyc; end
         if (cyc < hold && valid_ddr_cmd) cmd_in_hold++;
         if (cyc < hold && !busy) idle_in_hold++;
         acc = valid_ddr_rd_data && ddr_rd_data_ready;
         if (acc) begin pend--; widx++; nacc++; if (prev_acc) adj_acc++; end
         prev_acc = acc;
         if (valid_ddr_cmd && ncmd < 16) begin
            cmd_adr[ncmd] = load_ddr_base_adr; cmd_len[ncmd] = load_ddr_length;
            ncmd++; pend += int'(load_ddr_length);
         end
         @(negedge clk);
         if (done_cnt > 0 && cyc >= done_cyc + 3) begin timed_out = 1'b0; break; end
      end
      reset = 1'b0; conv_load_start = 1'b0; valid_ddr_rd_data = 1'b0; ddr_cmd_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({busy, conv_load_done, ddr_rd_data_ready, valid_ddr_cmd} !== 4'b0) begin
         n_fail++; $display("FAIL reset_status got=%b exp=0000", {busy, conv_load_done, ddr_rd_data_ready, valid_ddr_cmd});
      end
      n_chk++;
      if (buf_we !== 3'b0 || buf_wr_adr !== 16'd0 || buf_wr_data !== 512'd0) begin
         n_fail++; $display("FAIL reset_wrport we=%b adr=%0d exp 0", buf_we, buf_wr_adr);
      end
      n_chk++;
      if (load_ddr_length !== 16'd0 || load_ddr_base_adr !== 32'd0) begin
         n_fail++; $display("FAIL reset_cmd len=%0d adr=%h exp 0", load_ddr_length, load_ddr_base_adr);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mode1_basic;
      run_load(1, 1, 32, 5, 5, 32'h1000, 1, 1, 1, 0, 1'b0, 0);
      n_chk++;
      if (timed_out !== 1'b0 || done_cnt !== 1) begin
         n_fail++; $display("FAIL m1_done timeout=%0d pulses=%0d exp 0/1", timed_out, done_cnt);
      end
      n_chk++;
      if (ncmd !== 1 || cmd_adr[0] !== 32'h1000 || cmd_len[0] !== 16'd16) begin
         n_fail++; $display("FAIL m1_cmd n=%0d adr=%h len=%0d exp 1/1000/16", ncmd, cmd_adr[0], cmd_len[0]);
      end
      n_chk++;
      if (nwr !== 16) begin n_fail++; $display("FAIL m1_nwr got=%0d exp=16", nwr); end
      for (int i = 0; i < 16 && i < nwr; i++) begin
         n_chk++;
         if (wr_we[i] !== 3'b001 || wr_adr[i] !== 16'(i) || wr_data[i] !== mk_word(i)) begin
            n_fail++; $display("FAIL m1_wr%0d we=%b adr=%0d exp we=001 adr=%0d", i, wr_we[i], wr_adr[i], i);
         end
      end
      n_chk++;
      if (adj_acc !== 15) begin n_fail++; $display("FAIL m1_stream back_to_back=%0d exp=15", adj_acc); end
      n_chk++;
      if (done_cyc !== last_wr_cyc + 1) begin
         n_fail++; $display("FAIL m1_done_timing done=%0d lastwr=%0d exp lastwr+1", done_cyc, last_wr_cyc);
      end
   endtask

   task automatic test_mode0_basic;
      run_load(0, 1, 32, 5, 5, 32'h1000, 1, 1, 1, 0, 1'b0, 0);
      n_chk++;
      if (timed_out !== 1'b0 || done_cnt !== 1) begin
         n_fail++; $display("FAIL m0_done timeout=%0d pulses=%0d exp 0/1", timed_out, done_cnt);
      end
      n_chk++;
      if (ncmd !== 1 || cmd_adr[0] !== 32'h1000 || cmd_len[0] !== 16'd16) begin
         n_fail++; $display("FAIL m0_cmd n=%0d adr=%h len=%0d exp 1/1000/16", ncmd, cmd_adr[0], cmd_len[0]);
      end
      n_chk++;
      if (nwr !== 32) begin n_fail++; $display("FAIL m0_nwr got=%0d exp=32", nwr); end
      for (int i = 0; i < 32 && i < nwr; i++) begin
         n_chk++;
         if (wr_we[i] !== 3'b001 || wr_adr[i] !== 16'(i) || wr_data[i] !== half_of(i / 2, (i % 2) == 1)) begin
            n_fail++; $display("FAIL m0_wr%0d we=%b adr=%0d exp we=001 adr=%0d", i, wr_we[i], wr_adr[i], i);
         end
      end
      n_chk++;
      if (nacc !== 16 || adj_acc !== 0) begin
         n_fail++; $display("FAIL m0_ready_toggle accepts=%0d adjacent=%0d exp 16/0", nacc, adj_acc);
      end
      n_chk++;
      if (done_cyc !== last_wr_cyc + 1) begin
         n_fail++; $display("FAIL m0_done_timing done=%0d lastwr=%0d exp lastwr+1", done_cyc, last_wr_cyc);
      end
   endtask

   task automatic test_multi_chunk_rows;
      logic [31:0] ea;
      run_load(1, 3, 40, 6, 5, 32'h2000, 1, 1, 1, 0, 1'b0, 0);
      n_chk++;
      if (timed_out !== 1'b0 || done_cnt !== 1 || ncmd !== 6 || nwr !== 60) begin
         n_fail++; $display("FAIL mc_counts timeout=%0d done=%0d cmds=%0d wr=%0d exp 0/1/6/60", timed_out, done_cnt, ncmd, nwr);
      end
      for (int c = 0; c < 6 && c < ncmd; c++) begin
         ea = 32'h2000 + 32'((c / 2) * 32 + (c % 2) * 16);
         n_chk++;
         if (cmd_adr[c] !== ea || cmd_len[c] !== ((c % 2) ? 16'd4 : 16'd16)) begin
            n_fail++; $display("FAIL mc_cmd%0d adr=%h len=%0d exp adr=%h len=%0d", c, cmd_adr[c], cmd_len[c], ea, (c % 2) ? 4 : 16);
         end
      end
      for (int n = 0; n < 60 && n < nwr; n++) begin
         n_chk++;
         if (wr_we[n] !== 3'(1 << (n / 20)) || wr_adr[n] !== 16'(n % 20) || wr_data[n] !== mk_word(n)) begin
            n_fail++; $display("FAIL mc_wr%0d we=%b adr=%0d exp we=%b adr=%0d", n, wr_we[n], wr_adr[n], 3'(1 << (n / 20)), n % 20);
         end
      end
   endtask

   task automatic test_odd_pif;
      // origin y=1,x=32,f=2 (0-based) in a 32ch x 32px layer: 0x3000+16+16+1
      run_load(0, 1, 5, 5, 5, 32'h3000, 2, 33, 3, 0, 1'b0, 0);
      n_chk++;
      if (ncmd !== 1 || cmd_adr[0] !== 32'h3021 || cmd_len[0] !== 16'd3) begin
         n_fail++; $display("FAIL odd_cmd n=%0d adr=%h len=%0d exp 1/3021/3", ncmd, cmd_adr[0], cmd_len[0]);
      end
      n_chk++;
      if (nwr !== 5 || done_cnt !== 1) begin
         n_fail++; $display("FAIL odd_nwr got=%0d done=%0d exp 5/1", nwr, done_cnt);
      end
      for (int i = 0; i < 5 && i < nwr; i++) begin
         n_chk++;
         if (wr_adr[i] !== 16'(i) || wr_data[i] !== half_of(i / 2, (i % 2) == 1)) begin
            n_fail++; $display("FAIL odd_wr%0d adr=%0d exp %0d", i, wr_adr[i], i);
         end
      end
   endtask

   task automatic test_cmd_stall;
      run_load(1, 1, 32, 5, 5, 32'h1000, 1, 1, 1, 10, 1'b1, 0);
      n_chk++;
      if (cmd_in_hold !== 0 || idle_in_hold !== 0) begin
         n_fail++; $display("FAIL stall_hold cmds=%0d idle=%0d exp 0/0", cmd_in_hold, idle_in_hold);
      end
      n_chk++;
      if (ncmd !== 1 || nwr !== 16 || done_cnt !== 1) begin
         n_fail++; $display("FAIL stall_restart cmds=%0d wr=%0d done=%0d exp 1/16/1", ncmd, nwr, done_cnt);
      end
   endtask

   task automatic test_reset_mid_data;
      run_load(0, 1, 32, 5, 5, 32'h1000, 1, 1, 1, 0, 1'b0, 8);
      n_chk++;
      if (post_zero !== 1'b1 || done_cnt !== 0) begin
         n_fail++; $display("FAIL abort_outputs zero=%0d done=%0d exp 1/0", post_zero, done_cnt);
      end
      run_load(1, 1, 32, 5, 5, 32'h1000, 1, 1, 1, 0, 1'b0, 0);
      n_chk++;
      if (ncmd !== 1 || cmd_adr[0] !== 32'h1000 || nwr !== 16 || done_cnt !== 1) begin
         n_fail++; $display("FAIL abort_reload cmds=%0d adr=%h wr=%0d done=%0d exp 1/1000/16/1", ncmd, cmd_adr[0], nwr, done_cnt);
      end
      n_chk++;
      if (nwr < 16 || wr_adr[15] !== 16'd15 || wr_data[0] !== mk_word(0)) begin
         n_fail++; $display("FAIL abort_reload_data lastadr=%0d exp 15", wr_adr[15]);
      end
   endtask

   initial begin
      reset = 1'b1; conv_load_start = 1'b0; input_ddr_layer_base_adr = 32'd0;
      mode = 4'd0; if_in_2pow = 4'd5; ix_in_2pow = 4'd5;
      cur_ix_start = 16'd1; cur_iy_start = 16'd1; cur_if_start = 16'd1;
      cur_piy = 16'd1; cur_pif = 16'd1; ddr_cmd_ready = 1'b0;
      ddr_rd_data = 512'd0; valid_ddr_rd_data = 1'b0;
      test_reset;
      test_mode1_basic;
      test_mode0_basic;
      test_multi_chunk_rows;
      test_odd_pif;
      test_cmd_stall;
      test_reset_mid_data;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
